// File: rtl/bp_update_sched_if.sv
// Bundle between branch-resolution sources and the predictor-table write scheduler.
// Master drives the source updates and flush/clear controls. Slave drives the table write port.
interface bp_update_sched_if #(
  parameter int N_SRC    = 2,
  parameter int DEPTH    = 8,
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N_SRC-1:0]           src_valid;
  logic [N_SRC-1:0][XLEN-1:0] src_pc;
  logic [N_SRC-1:0][XLEN-1:0] src_target;
  logic [N_SRC-1:0]           src_taken;
  logic                       src_ready;
  logic                       flush;
  logic                       clr_req;
  logic                       upd_en;
  logic [XLEN-1:0]            upd_pc;
  logic [XLEN-1:0]            upd_target;
  logic                       upd_taken;
  logic                       clr_en;
  logic [IDX_BITS-1:0]        clr_idx;
  logic                       clr_busy;
  logic [CW-1:0]              occupancy;

  modport master (
    output src_valid, src_pc, src_target, src_taken, flush, clr_req,
    input  src_ready, upd_en, upd_pc, upd_target, upd_taken,
    input  clr_en, clr_idx, clr_busy, occupancy
  );

  modport slave (
    input  src_valid, src_pc, src_target, src_taken, flush, clr_req,
    output src_ready, upd_en, upd_pc, upd_target, upd_taken,
    output clr_en, clr_idx, clr_busy, occupancy
  );
endinterface

// File: rtl/bp_update_sched.sv
// Orders resolved-branch updates into the single predictor write port.
// Drains one update per cycle and sequences full-table clear sweeps.
module bp_update_sched #(
  parameter int N_SRC    = 2,
  parameter int DEPTH    = 8,
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bp_update_sched_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            tk;
  } ent_t;

  ent_t                r_mem [DEPTH];
  logic [PW-1:0]       r_head, r_tail;
  logic [CW-1:0]       r_cnt;
  logic [0:0]          r_state;
  logic [IDX_BITS-1:0] r_idx;
  logic                r_upd_en;
  ent_t                r_upd;

  logic                   w_ready, w_enq_ok, w_pop;
  logic [CW-1:0]          w_n_enq;
  logic [N_SRC-1:0][PW-1:0] w_slot;

  assign w_ready  = (r_cnt <= CW'(DEPTH - N_SRC));
  assign w_enq_ok = w_ready && !bus.flush;
  // A pop on the clr_req cycle would land upd_en in the first sweep cycle.
  assign w_pop    = (r_state == S_RUN) && !bus.clr_req && !bus.flush && (r_cnt != '0);

  // Compact valid sources onto consecutive tail slots, lowest index oldest.
  always_comb begin
    w_n_enq = '0;
    for (int s = 0; s < N_SRC; s++) begin
      w_slot[s] = r_tail + w_n_enq[PW-1:0];
      if (bus.src_valid[s]) w_n_enq = w_n_enq + CW'(1);
    end
    if (!w_enq_ok) w_n_enq = '0;
  end

  always_ff @(posedge i_clk) begin
    for (int s = 0; s < N_SRC; s++)
      if (w_enq_ok && bus.src_valid[s])
        r_mem[w_slot[s]] <= '{pc: bus.src_pc[s], tgt: bus.src_target[s], tk: bus.src_taken[s]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      r_head <= r_head + PW'(w_pop);
      r_tail <= r_tail + w_n_enq[PW-1:0];
      r_cnt  <= r_cnt + w_n_enq - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_upd_en <= 1'b0;
      r_upd    <= '0;
    end else begin
      r_upd_en <= w_pop;
      if (w_pop) r_upd <= r_mem[r_head];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_idx   <= '0;
    end else if (r_state == S_CLEAR) begin
      r_idx <= r_idx + IDX_BITS'(1);
      if (&r_idx) r_state <= S_RUN;
    end else if (bus.clr_req) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end
  end

  assign bus.src_ready  = w_ready;
  assign bus.occupancy  = r_cnt;
  assign bus.upd_en     = r_upd_en;
  assign bus.upd_pc     = r_upd.pc;
  assign bus.upd_target = r_upd.tgt;
  assign bus.upd_taken  = r_upd.tk;
  assign bus.clr_en     = (r_state == S_CLEAR);
  assign bus.clr_busy   = (r_state == S_CLEAR);
  assign bus.clr_idx    = r_idx;
endmodule

// File: tb/tb_bp_update_sched.sv
// Randomized and directed bench for bp_update_sched with a queue-level reference model.
// The model updates on the clock edge; a negedge monitor compares and pops the scoreboard.
module tb_bp_update_sched;
  localparam int N_SRC = 2, DEPTH = 8, IDX_BITS = 6, XLEN = 32;
  localparam int SWEEP = 1 << IDX_BITS;

  typedef struct { logic [31:0] pc; logic [31:0] tgt; logic tk; } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_update_sched_if #(.N_SRC(N_SRC), .DEPTH(DEPTH), .IDX_BITS(IDX_BITS), .XLEN(XLEN)) bus();
  bp_update_sched #(.N_SRC(N_SRC), .DEPTH(DEPTH), .IDX_BITS(IDX_BITS), .XLEN(XLEN))
    dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

  int checks = 0, errors = 0;

  ent_t mq[$];
  ent_t exp_q[$];
  ent_t m_last = '{pc: 0, tgt: 0, tk: 0};
  bit   m_upd = 0, m_clear = 0, m_blocked = 0, m_rdy = 1;
  int   m_idx = 0;
  logic [1:0] h_v, h_tk;
  logic [N_SRC-1:0][31:0] h_pc, h_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of entries; one pop per cycle outside a sweep, flush empties it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); exp_q.delete();
      m_upd = 0; m_clear = 0; m_idx = 0; m_blocked = 0;
      m_last = '{pc: 0, tgt: 0, tk: 0};
    end else begin
      if (m_blocked)
        assert (bus.src_valid == h_v && bus.src_pc == h_pc && bus.src_target == h_t &&
                bus.src_taken == h_tk) else $error("source dropped a held request");
      m_rdy = (mq.size() <= DEPTH - N_SRC);
      m_upd = 0;
      if (!m_clear && !bus.clr_req && !bus.flush && mq.size() > 0) begin
        m_last = mq.pop_front();
        exp_q.push_back(m_last);
        m_upd = 1;
      end
      if (bus.flush) mq.delete();
      else if (m_rdy)
        for (int s = 0; s < N_SRC; s++)
          if (bus.src_valid[s])
            mq.push_back('{pc: bus.src_pc[s], tgt: bus.src_target[s], tk: bus.src_taken[s]});
      m_blocked = (bus.src_valid != 0) && !m_rdy && !bus.flush;
      h_v = bus.src_valid; h_pc = bus.src_pc; h_t = bus.src_target; h_tk = bus.src_taken;
      if (m_clear) begin
        if (m_idx == SWEEP - 1) begin m_clear = 0; m_idx = 0; end
        else m_idx++;
      end else if (bus.clr_req) begin
        m_clear = 1; m_idx = 0;
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    chk("occupancy", bus.occupancy, mq.size());
    chk("src_ready", bus.src_ready, mq.size() <= DEPTH - N_SRC);
    chk("upd_en", bus.upd_en, m_upd);
    chk("clr_en", bus.clr_en, m_clear);
    chk("clr_busy", bus.clr_busy, m_clear);
    chk("clr_idx", bus.clr_idx, m_idx);
    chk("en_exclusive", bus.upd_en & bus.clr_en, 0);
    if (bus.upd_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL upd_unexpected actual=upd_en required=no_update at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("upd_taken", bus.upd_taken, e.tk);
      end
    end
    chk("upd_pc", bus.upd_pc, m_last.pc);
    chk("upd_target", bus.upd_target, m_last.tgt);
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] tk, input logic fl, input logic cr);
    bus.src_valid = v;
    bus.src_pc[0] = p0; bus.src_pc[1] = p1;
    bus.src_target[0] = p0 ^ 32'h00ab_c000; bus.src_target[1] = ~p1;
    bus.src_taken = tk; bus.flush = fl; bus.clr_req = cr;
    @(posedge clk); #2;
    bus.flush = 1'b0; bus.clr_req = 1'b0;
    for (int i = 0; i < 40 && m_blocked; i++) begin @(posedge clk); #2; end
    if (m_blocked) begin
      checks++; errors++;
      $display("FAIL enqueue_timeout actual=blocked required=accepted at %0t", $time);
    end
    bus.src_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    rst = 1'b1;
    bus.src_valid = 2'b11; bus.src_pc = '0; bus.src_target = '0; bus.src_taken = '0;
    bus.flush = 1'b0; bus.clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; bus.src_valid = '0;
    idle(2);

    drive(2'b11, 32'h100, 32'h104, 2'b01, 0, 0);
    idle(4);

    for (int i = 0; i < 10; i++) drive(2'b11, 32'h2000 + 8 * i, 32'h2004 + 8 * i, i[1:0], 0, 0);
    idle(10);

    drive(2'b11, 32'h300, 32'h304, 2'b10, 0, 0);
    drive(2'b10, 32'h0, 32'h308, 2'b10, 0, 1);
    idle(SWEEP + 6);

    for (int i = 0; i < 4; i++) drive(2'b11, 32'h400 + 8 * i, 32'h404 + 8 * i, 2'b11, 0, 0);
    drive(2'b01, 32'hdead, 32'h0, 2'b01, 1, 0);
    idle(4);

    drive(2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 40 && m_idx != 10; i++) idle(1);
    drive(2'b11, 32'h500, 32'h504, 2'b01, 0, 1);
    idle(SWEEP);

    drive(2'b00, 0, 0, 0, 0, 1);
    idle(20);
    #1 rst = 1'b1;
    #1 chk("async_rst_busy", bus.clr_busy, 0);
    chk("async_rst_clr_en", bus.clr_en, 0);
    chk("async_rst_occ", bus.occupancy, 0);
    @(posedge clk); #2 rst = 1'b0;
    idle(2);

    for (int c = 0; c < 700; c++) begin
      if (!m_blocked) begin
        bus.src_valid = 2'($urandom);
        bus.src_pc[0] = $urandom; bus.src_pc[1] = $urandom;
        bus.src_target[0] = $urandom; bus.src_target[1] = $urandom;
        bus.src_taken = 2'($urandom);
      end
      bus.flush = ($urandom_range(0, 39) == 0);
      bus.clr_req = ($urandom_range(0, 179) == 0);
      @(posedge clk); #2;
    end
    bus.src_valid = '0; bus.flush = 1'b0; bus.clr_req = 1'b0;
    for (int i = 0; i < 200 && (mq.size() != 0 || m_clear); i++) idle(1);
    idle(3);
    chk("final_model_empty", mq.size() + exp_q.size(), 0);
    chk("final_occupancy", bus.occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
